// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;
   localparam int INSTRUCTION_BYTES = 4;
   typedef enum logic [1:0] {REQUEST, WAIT, DISCARD, HALT} fetch_state;
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] address;
   } fetch_packet;
endpackage

// File: rtl/skid_buffer_port.sv
// skid_buffer_port: valid/ready channel carrying a fetch_packet to the decoder.
interface skid_buffer_port;
   import fetch_pkg::*;
   logic valid;
   logic ready;
   fetch_packet data;
   modport downstream (output valid, output data, input ready);
   modport upstream (input valid, input data, output ready);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch packets; flush overrides push and pop.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  fetch_packet data_in,
   output fetch_packet head,
   output logic        full,
   output logic        empty,
   output logic [1:0]  occupancy
);
   fetch_packet slot0, slot1;
   logic [1:0] count;
   logic do_pop, do_push, write_second;
   always_comb begin
      do_pop = pop && count != 2'd0;
      do_push = push && (count != 2'd2 || do_pop);
      write_second = do_pop ? count == 2'd2 : count == 2'd1;
   end
   // Pop shifts slot1 forward first; a push into slot0 then overrides it.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         count <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         if (do_pop) slot0 <= slot1;
         if (do_push && !write_second) slot0 <= data_in;
         if (do_push && write_second) slot1 <= data_in;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   assign head = slot0;
   assign full = count == 2'd2;
   assign empty = count == 2'd0;
   assign occupancy = count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding instruction fetch and 2-entry decode queue.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       mem_req_valid,
   input  logic                       mem_req_ready,
   output logic [31:0]                mem_req_address,
   input  logic                       mem_resp_valid,
   input  logic [31:0]                mem_resp_data,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_address,
   output logic                       misaligned,
   skid_buffer_port.downstream        decoder
);
   fetch_state state;
   logic [31:0] pc;
   logic full, empty, handshake, push, pop, bad_target;
   logic [1:0] occupancy;
   fetch_packet head;
   always_comb begin
      mem_req_valid = !reset && state == REQUEST && occupancy < 2'd2;
      handshake = mem_req_valid && mem_req_ready;
      bad_target = redirect_address[1:0] != 2'b00;
      push = state == WAIT && mem_resp_valid && !redirect_valid && !full;
      pop = decoder.valid && decoder.ready;
   end
   assign mem_req_address = pc;
   assign decoder.valid = !empty;
   assign decoder.data = head;
   // A redirect leaves a request outstanding if one was just accepted or is
   // still awaiting its response; that response must then be discarded.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= REQUEST;
         pc <= RESET_VECTOR;
         misaligned <= 1'b0;
      end else if (state != HALT && redirect_valid) begin
         if (bad_target) begin
            misaligned <= 1'b1;
            state <= HALT;
         end else begin
            pc <= redirect_address;
            state <= (handshake || (state != REQUEST && !mem_resp_valid)) ? DISCARD : REQUEST;
         end
      end else if (state != HALT) begin
         if (push) pc <= pc + 32'(INSTRUCTION_BYTES);
         if (handshake) state <= WAIT;
         else if (state != REQUEST && mem_resp_valid) state <= REQUEST;
      end
   fetch_queue queue (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .data_in   ('{instruction: mem_resp_data, address: pc}),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a 1..3 cycle memory model.
module tb_fetch_unit;
   import fetch_pkg::*;
   localparam logic [31:0] KEY = 32'h1357_9BDF;
   logic clock = 0, reset = 1, mem_req_ready = 1, mem_resp_valid = 0, redirect_valid = 0;
   logic mem_req_valid, misaligned;
   logic [31:0] mem_req_address, mem_resp_data = 0, redirect_address = 0, mem_addr;
   int resp_delay = 1, errors = 0, checks = 0, cyc = 0, seen, n;
   bit found;
   logic [31:0] log_addr[$], log_inst[$];
   int log_cyc[$];
   skid_buffer_port decoder ();
   fetch_unit #(.RESET_VECTOR(32'h100)) dut (
      .clock            (clock),
      .reset            (reset),
      .mem_req_valid    (mem_req_valid),
      .mem_req_ready    (mem_req_ready),
      .mem_req_address  (mem_req_address),
      .mem_resp_valid   (mem_resp_valid),
      .mem_resp_data    (mem_resp_data),
      .redirect_valid   (redirect_valid),
      .redirect_address (redirect_address),
      .misaligned       (misaligned),
      .decoder          (decoder)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock)
      if (decoder.valid && decoder.ready) begin
         log_addr.push_back(decoder.data.address);
         log_inst.push_back(decoder.data.instruction);
         log_cyc.push_back(cyc);
      end
   // Memory: word = address ^ KEY, returned resp_delay cycles after acceptance.
   always @(negedge clock)
      if (mem_req_valid && mem_req_ready) begin
         mem_addr = mem_req_address;
         repeat (resp_delay) @(posedge clock);
         #1 mem_resp_valid = 1;
         mem_resp_data = mem_addr ^ KEY;
         @(posedge clock);
         #1 mem_resp_valid = 0;
      end
   task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task step(input int cycles);
      repeat (cycles) @(posedge clock);
      #1;
   endtask
   task clear_log;
      log_addr.delete();
      log_inst.delete();
      log_cyc.delete();
   endtask
   task do_reset;
      reset = 1;
      step(2);
      clear_log();
      reset = 0;
   endtask
   task expect_log(input string tag, input int i, input logic [31:0] a);
      if (log_addr.size() > i) begin
         check({tag, "_addr"}, log_addr[i], a);
         check({tag, "_inst"}, log_inst[i], a ^ KEY);
      end else check({tag, "_count"}, log_addr.size(), i + 1);
   endtask
   task redirect(input logic [31:0] a);
      redirect_valid = 1;
      redirect_address = a;
      step(1);
      redirect_valid = 0;
   endtask
   task wait_req(input logic [31:0] a);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         found = mem_req_valid && mem_req_address == a;
      end
      check("req_seen", found, 1);
   endtask
   initial begin
      decoder.ready = 1;
      step(2);
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_req_addr", mem_req_address, 32'h100);
      check("rst_dec_valid", decoder.valid, 0);
      check("rst_dec_inst", decoder.data.instruction, 0);
      check("rst_dec_addr", decoder.data.address, 0);
      check("rst_misaligned", misaligned, 0);
      // Streaming at one instruction per two cycles.
      reset = 0;
      step(12);
      expect_log("t1_0", 0, 32'h100);
      expect_log("t1_1", 1, 32'h104);
      expect_log("t1_2", 2, 32'h108);
      if (log_cyc.size() > 1) check("t1_spacing", log_cyc[1] - log_cyc[0], 2);
      // Decoder stall fills the queue, release drains back-to-back.
      decoder.ready = 0;
      do_reset();
      step(10);
      check("t2_req_stalled", mem_req_valid, 0);
      check("t2_dec_valid", decoder.valid, 1);
      check("t2_hold_addr", decoder.data.address, 32'h100);
      check("t2_no_pop", log_addr.size(), 0);
      decoder.ready = 1;
      step(10);
      expect_log("t2_0", 0, 32'h100);
      expect_log("t2_1", 1, 32'h104);
      expect_log("t2_2", 2, 32'h108);
      expect_log("t2_3", 3, 32'h10C);
      if (log_cyc.size() > 1) check("t2_b2b", log_cyc[1] - log_cyc[0], 1);
      // Redirect with 0x108 outstanding and 0x104 buffered.
      decoder.ready = 0;
      resp_delay = 2;
      do_reset();
      step(12);
      check("t3_full", mem_req_valid, 0);
      decoder.ready = 1;
      step(1);
      decoder.ready = 0;
      wait_req(32'h108);
      step(1);
      redirect(32'h200);
      check("t3_flushed", decoder.valid, 0);
      check("t3_discard_noreq", mem_req_valid, 0);
      check("t3_new_pc", mem_req_address, 32'h200);
      resp_delay = 1;
      decoder.ready = 1;
      step(10);
      expect_log("t3_0", 0, 32'h100);
      expect_log("t3_1", 1, 32'h200);
      expect_log("t3_2", 2, 32'h204);
      // Misaligned redirect halts fetch until reset.
      do_reset();
      step(5);
      redirect(32'h203);
      n = log_addr.size();
      seen = 0;
      repeat (10) begin
         @(negedge clock);
         if (mem_req_valid) seen++;
      end
      check("t4_no_req", seen, 0);
      check("t4_misaligned", misaligned, 1);
      check("t4_dec_valid", decoder.valid, 0);
      check("t4_no_delivery", log_addr.size(), n);
      reset = 1;
      #1;
      check("t4_rst_misaligned", misaligned, 0);
      check("t4_rst_req_valid", mem_req_valid, 0);
      // PC wraps past the top of the address space.
      do_reset();
      step(3);
      redirect(32'hFFFF_FFFC);
      clear_log();
      step(12);
      expect_log("t5_0", 0, 32'hFFFF_FFFC);
      expect_log("t5_1", 1, 32'h0000_0000);
      expect_log("t5_2", 2, 32'h0000_0004);
      // Reset during WAIT; the stale response arrives afterwards.
      resp_delay = 3;
      do_reset();
      wait_req(32'h100);
      step(1);
      reset = 1;
      mem_req_ready = 0;
      step(1);
      reset = 0;
      clear_log();
      step(1);
      check("t6_stall_valid", mem_req_valid, 1);
      check("t6_stall_addr", mem_req_address, 32'h100);
      step(1);
      check("t6_stable_addr", mem_req_address, 32'h100);
      step(2);
      check("t6_stale_dropped", decoder.valid, 0);
      check("t6_no_delivery", log_addr.size(), 0);
      resp_delay = 1;
      mem_req_ready = 1;
      step(10);
      expect_log("t6_0", 0, 32'h100);
      expect_log("t6_1", 1, 32'h104);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32E core, directly upstream of the decoder. Holds the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words with their addresses in a 2-entry queue. The queue drains to the decoder through a `skid_buffer_port.downstream`. Execute can redirect the PC, which flushes all in-flight and buffered fetches.

## Interface
- `RESET_VECTOR`, default `32'h0000_0000`: PC after reset. Must be word-aligned.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous reset, active-high.
- `mem_req_valid` output 1: read request is presented.
- `mem_req_ready` input 1: memory accepts the request this cycle.
- `mem_req_address` output 32: word-aligned fetch address.
- `mem_resp_valid` input 1: read data is returned. One pulse per accepted request, at least 1 cycle after acceptance.
- `mem_resp_data` input 32: instruction word.
- `redirect_valid` input 1: execute demands a new PC (taken branch, JAL, or JALR).
- `redirect_address` input 32: new PC.
- `misaligned` output 1: sticky error flag, set when a redirect target has `[1:0] != 0`.
- `decoder` `skid_buffer_port.downstream`: exposes `valid`, `ready`, `data.instruction` [31:0] and `data.address` [31:0].

## Operation
- FSM states:
  - `REQUEST`: `mem_req_valid=1` when the queue has at least one free slot.
  - `WAIT`: one request is outstanding.
  - `DISCARD`: one request is outstanding, but its response is stale.
  - `HALT`: a misaligned redirect occurred; no further requests.
- FSM transitions:
  - `REQUEST` → `WAIT` on request handshake.
  - `WAIT` → `REQUEST` on `mem_resp_valid`. The response word and its request address are pushed into the queue, and the PC is incremented by 4.
  - `WAIT` + `redirect_valid` → `DISCARD`. `DISCARD` → `REQUEST` on `mem_resp_valid`, and the response is dropped.
- At most one request is outstanding. The address presented is the latched PC, which stays stable while `mem_req_valid=1 && !mem_req_ready`.
- Redirect, aligned target:
  - PC ← `redirect_address`.
  - Queue is cleared in the same cycle.
  - `decoder.valid` drops the next cycle.
  - Redirect in `REQUEST` with a pending but unaccepted request: the request is withdrawn, and the new address appears the next cycle.
  - Redirect has priority over a simultaneous push, pop, or handshake. The handshake in that cycle is still counted as outstanding, so the FSM goes to `DISCARD`.
- Redirect, misaligned target: `misaligned` ← 1, state → `HALT`, queue is flushed. Only `reset` leaves `HALT`.
- Queue push and pop in the same cycle:
  - Full queue: both are allowed, with the pop taking effect first.
  - Empty queue: the push lands and is visible the next cycle. There is no combinational bypass.
- Decoder handshake: an entry is popped when `decoder.valid && decoder.ready`. `data` holds its value while `valid && !ready`.
- PC arithmetic is 32-bit and wraps from `32'hFFFF_FFFC` to `0` silently.
- Reset, applied at any time including mid-request:
  - Outputs: `mem_req_valid=0`, `mem_req_address=RESET_VECTOR`, `decoder.valid=0`, `decoder.data=0`, `misaligned=0`.
  - Internal: queue empty, state `REQUEST`, PC `RESET_VECTOR`.
  - A response arriving after reset for a request issued before reset is ignored: after reset the FSM is not in `WAIT`.

## Timing
- Outputs are registered, except that `mem_req_valid` is a combinational function of state and queue occupancy.
- With a memory that has 1-cycle response and `mem_req_ready` tied high, sustained throughput is one instruction per 2 cycles.
- Latency from `reset` deassertion to the first `decoder.valid` is `mem_req_ready` wait + response latency + 1 cycle.
- Latency from redirect to the first valid at the new target is at least 3 cycles: request, response, queue register.
- A full queue stalls request issue in the same cycle, via the occupancy check.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state` enum {`REQUEST`, `WAIT`, `DISCARD`, `HALT`}.
  - `fetch_packet` struct {`instruction`, `address`}, reusing the same layout the decoder reads.
  - `INSTRUCTION_BYTES = 4`.
- Sub-module `fetch_queue`: 2-entry FIFO of `fetch_packet` with push, pop, flush, full, empty, and occupancy outputs. Flush has priority over push and pop.

## Test plan
- Reset with `RESET_VECTOR=32'h100`, memory with 1-cycle response, decoder ready → decoder receives addresses 0x100, 0x104, 0x108 in order with the matching instruction words, one every 2 cycles.
- Decoder `ready=0` for 10 cycles → queue fills with 2 entries and `mem_req_valid` drops. On release, 0x100 and 0x104 are delivered back-to-back and fetch resumes at 0x108, with no loss and no duplicate.
- Redirect to 0x200 while a request for 0x108 is outstanding → 0x108 response is dropped, queue is flushed, and the next delivered address is 0x200.
- Redirect to 0x203 → `misaligned=1`, no further `mem_req_valid`, `decoder.valid=0`. Asserting `reset` clears `misaligned`.
- PC at 0xFFFF_FFFC → next request address is 0x0000_0000.
- Assert `reset` while in `WAIT`, then deliver the stale response → it is not enqueued, and the first delivered address is `RESET_VECTOR`.
